// File: rtl/dft_pkg.sv
// Shared types and helpers for the direct-DFT MAC engine.
// Optional build macro: INVERSE_DFT_EN (adds the 'inverse' port on the top).
package dft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] re;
        logic [DATA_W_DEF-1:0] im;
    } complex_t;

    // Arithmetic shift right by sh (sh >= 1) with round half-up, then clamp to a
    // signed dw-bit range. The accumulator is sign-extended to 64 bits first, so
    // this covers any configuration whose accumulator fits in 64 bits.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] v,
        input  int unsigned        sh,
        input  int unsigned        dw,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dft_cmac.sv
// Complex multiply-accumulate datapath: registered product, wide accumulator,
// and the registered round/saturate conversion of the finished bin.
module dft_cmac
    import dft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SH_W   = $clog2(ADDR_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] smp_rdata,
    input  logic [2*TW_W-1:0]   tw_rdata,
    input  logic                vld_p1,
    input  logic                conj,
    input  logic                acc_clr,
    input  logic                conv_en,
    input  logic [SH_W-1:0]     shift,
    output logic [2*DATA_W-1:0] res_data,
    output logic                conv_sat
);

    localparam int PROD_W = DATA_W + TW_W + 1;
    localparam int ACC_W  = DATA_W + TW_W + ADDR_W + 1;

    logic signed [DATA_W-1:0] xr, xi;
    logic signed [TW_W-1:0]   wr, wi;
    logic signed [TW_W:0]     wi_eff;
    logic signed [PROD_W-1:0] xr_e, xi_e, wr_e, wi_e;
    logic signed [PROD_W-1:0] pr_c, pi_c;
    logic signed [PROD_W-1:0] pr_p2, pi_p2;
    logic                     vld_p2;
    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [ACC_W-1:0]  sum_re, sum_im;
    logic signed [DATA_W-1:0] cv_re, cv_im;
    logic                     sat_re, sat_im;
    int unsigned              sh_amt;

    assign xr = smp_rdata[2*DATA_W-1:DATA_W];
    assign xi = smp_rdata[DATA_W-1:0];
    assign wr = tw_rdata[2*TW_W-1:TW_W];
    assign wi = tw_rdata[TW_W-1:0];

    // One extra bit so that negating the most negative twiddle cannot wrap.
    assign wi_eff = conj ? -((TW_W+1)'(wi)) : (TW_W+1)'(wi);

    assign xr_e = PROD_W'(xr);
    assign xi_e = PROD_W'(xi);
    assign wr_e = PROD_W'(wr);
    assign wi_e = PROD_W'(wi_eff);

    assign pr_c = xr_e * wr_e - xi_e * wi_e;
    assign pi_c = xr_e * wi_e + xi_e * wr_e;

    // ---- stage 2: register the complex product of the returned read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            pr_p2  <= '0;
            pi_p2  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                pr_p2 <= pr_c;
                pi_p2 <= pi_c;
            end
        end
    end

    // Running sum including the product in flight, also feeds the conversion.
    always_comb begin
        sum_re = acc_re;
        sum_im = acc_im;
        if (vld_p2) begin
            sum_re = acc_re + ACC_W'(pr_p2);
            sum_im = acc_im + ACC_W'(pi_p2);
        end
    end

    // ---- stage 3: accumulate products, cleared at the start of every bin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (acc_clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (vld_p2) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
        end
    end

    // Drop the Q(TW_W-1) twiddle scaling plus the user shift, round, clamp.
    always_comb begin
        sh_amt   = 32'(TW_W - 1) + 32'(shift);
        cv_re    = DATA_W'(round_sat(64'(sum_re), sh_amt, DATA_W, sat_re));
        cv_im    = DATA_W'(round_sat(64'(sum_im), sh_amt, DATA_W, sat_im));
        conv_sat = sat_re | sat_im;
    end

    // ---- output: capture the converted bin as the FSM enters OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
        end else if (conv_en) begin
            res_data <= {cv_re, cv_im};
        end
    end

endmodule

// File: rtl/dft_mac_engine.sv
// Direct-DFT engine: walks n for each bin k, fetching samples and twiddles,
// and streams each finished bin out over valid/ready.
// Optional build macro: INVERSE_DFT_EN adds the 'inverse' input (conjugated
// twiddles, unnormalised IDFT).
module dft_mac_engine
    import dft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int SH_W  = $clog2(ADDR_W + 1)
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   points_m1,
    input  logic [SH_W-1:0]     scale_shift,
`ifdef INVERSE_DFT_EN
    input  logic                inverse,
`endif
    output logic [ADDR_W-1:0]   smp_addr,
    input  logic [2*DATA_W-1:0] smp_rdata,
    output logic [ADDR_W-1:0]   tw_addr,
    input  logic [2*TW_W-1:0]   tw_rdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0]   res_index,
    output logic                busy,
    output logic                done,
    output logic                sat_flag
);

    state_t            state;
    logic [ADDR_W-1:0] n_cnt, k_cnt, phase, n_last, res_index_r;
    logic [SH_W-1:0]   shift_lat;
    logic              inv_lat;
    logic              drain_cnt;
    logic              vld_p1;
    logic              busy_r, done_r, res_valid_r, sat_r;
    logic              acc_clr, conv_en, conv_sat;
    logic [ADDR_W:0]   n_total, phase_sum;
    logic [ADDR_W-1:0] phase_nxt;

`ifndef INVERSE_DFT_EN
    assign inv_lat = 1'b0;
`endif

    // Phase step p <- (p + k) mod N; p and k are both below N so one
    // conditional subtract suffices.
    assign n_total   = {1'b0, n_last} + (ADDR_W+1)'(1);
    assign phase_sum = {1'b0, phase} + {1'b0, k_cnt};
    assign phase_nxt = (phase_sum >= n_total) ? ADDR_W'(phase_sum - n_total)
                                              : ADDR_W'(phase_sum);

    assign acc_clr = ((state == IDLE) && start) ||
                     ((state == OUT) && res_ready && (k_cnt != n_last));
    assign conv_en = (state == DRAIN) && drain_cnt;

    // ---- stage 1: FSM, n/k counters, phase accumulator and address issue
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            n_cnt       <= '0;
            k_cnt       <= '0;
            phase       <= '0;
            n_last      <= '0;
            shift_lat   <= '0;
            drain_cnt   <= 1'b0;
            vld_p1      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_index_r <= '0;
            sat_r       <= 1'b0;
`ifdef INVERSE_DFT_EN
            inv_lat     <= 1'b0;
`endif
        end else begin
            // Read data lands one cycle after each issued address pair.
            vld_p1 <= (state == ISSUE);
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_last    <= points_m1;
                        shift_lat <= scale_shift;
`ifdef INVERSE_DFT_EN
                        inv_lat   <= inverse;
`endif
                        k_cnt     <= '0;
                        n_cnt     <= '0;
                        phase     <= '0;
                        sat_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (n_cnt == n_last) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        n_cnt <= n_cnt + ADDR_W'(1);
                        phase <= phase_nxt;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        res_valid_r <= 1'b1;
                        res_index_r <= k_cnt;
                        if (conv_sat) begin
                            sat_r <= 1'b1;
                        end
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        if (k_cnt == n_last) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            k_cnt <= k_cnt + ADDR_W'(1);
                            n_cnt <= '0;
                            phase <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dft_cmac #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W),
        .ADDR_W (ADDR_W),
        .SH_W   (SH_W)
    ) u_cmac (
        .clk       (clk),
        .rst       (Reset),
        .smp_rdata (smp_rdata),
        .tw_rdata  (tw_rdata),
        .vld_p1    (vld_p1),
        .conj      (inv_lat),
        .acc_clr   (acc_clr),
        .conv_en   (conv_en),
        .shift     (shift_lat),
        .res_data  (res_data),
        .conv_sat  (conv_sat)
    );

    assign smp_addr  = n_cnt;
    assign tw_addr   = phase;
    assign res_valid = res_valid_r;
    assign res_index = res_index_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign sat_flag  = sat_r;

endmodule

// File: tb/tb_dft_mac_engine.sv
// Directed bench for dft_mac_engine with behavioural sample RAM and Q15
// twiddle ROM (tables for N = 1, 4, 8). Build with INVERSE_DFT_EN to also
// exercise the conjugate-twiddle path.
module tb_dft_mac_engine;
    import dft_pkg::*;

    logic        clk;
    logic        Reset;
    logic        start;
    logic [11:0] points_m1;
    logic [3:0]  scale_shift;
`ifdef INVERSE_DFT_EN
    logic        inverse;
`endif
    logic [11:0] smp_addr;
    logic [31:0] smp_rdata;
    logic [11:0] tw_addr;
    logic [31:0] tw_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [11:0] res_index;
    logic        busy;
    logic        done;
    logic        sat_flag;

    int n_checks = 0;
    int n_err    = 0;

    complex_t           smp_mem [0:7];
    int                 rom_n;
    logic signed [15:0] got_re [0:7];
    logic signed [15:0] got_im [0:7];
    logic [11:0]        tw_log [$];
    logic [11:0]        mon_prev;
    logic               mon_en;
    logic               seen_valid;

    dft_mac_engine dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .points_m1   (points_m1),
        .scale_shift (scale_shift),
`ifdef INVERSE_DFT_EN
        .inverse     (inverse),
`endif
        .smp_addr    (smp_addr),
        .smp_rdata   (smp_rdata),
        .tw_addr     (tw_addr),
        .tw_rdata    (tw_rdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_index   (res_index),
        .busy        (busy),
        .done        (done),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp(-j*2*pi*m/8) in Q15; N=4 uses every second entry, N=1 only entry 0.
    function automatic logic [31:0] rom(input logic [11:0] a, input int n);
        logic [2:0] m;
        if (n == 8)      m = a[2:0];
        else if (n == 4) m = {a[1:0], 1'b0};
        else             m = 3'd0;
        case (m)
            3'd0:    rom = {16'h7FFF, 16'h0000};
            3'd1:    rom = {16'h5A82, 16'hA57E};
            3'd2:    rom = {16'h0000, 16'h8001};
            3'd3:    rom = {16'hA57E, 16'hA57E};
            3'd4:    rom = {16'h8001, 16'h0000};
            3'd5:    rom = {16'hA57E, 16'h5A82};
            3'd6:    rom = {16'h0000, 16'h7FFF};
            default: rom = {16'h5A82, 16'h5A82};
        endcase
    endfunction

    // One-cycle read latency memories.
    always @(posedge clk) begin
        smp_rdata <= smp_mem[smp_addr[2:0]];
        tw_rdata  <= rom(tw_addr, rom_n);
    end

    // Log the twiddle address on every new sample address while enabled.
    always @(negedge clk) begin
        if (mon_en && (smp_addr != mon_prev)) tw_log.push_back(tw_addr);
        mon_prev <= smp_addr;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_samples(input int v0, input int v1, input int v2, input int v3,
                               input int rest);
        for (int i = 0; i < 8; i++) begin
            smp_mem[i].re = 16'(rest);
            smp_mem[i].im = 16'h0000;
        end
        smp_mem[0].re = 16'(v0);
        smp_mem[1].re = 16'(v1);
        smp_mem[2].re = 16'(v2);
        smp_mem[3].re = 16'(v3);
    endtask

    // Runs one transform; optionally stalls bin stall_k for 5 cycles and
    // optionally pokes start/config while busy.
    task automatic run(input int npts, input int sh, input bit inv, input int stall_k,
                       input logic [31:0] stall_exp, input bit poke);
        int t;
        points_m1   = 12'(npts - 1);
        scale_shift = 4'(sh);
        rom_n       = npts;
`ifdef INVERSE_DFT_EN
        inverse     = inv;
`else
        if (inv) $display("note: inverse request ignored in forward-only build");
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("busy_after_start_n%0d", npts), busy, 1);
        if (poke) begin
            @(negedge clk);
            @(negedge clk);
            start       = 1'b1;
            points_m1   = 12'd0;
            scale_shift = 4'd3;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < npts; k++) begin
            t = 0;
            while (!res_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("res_valid_wait_k%0d", k), res_valid, 1);
            chk($sformatf("res_index_k%0d", k), res_index, k);
            got_re[k] = res_data[31:16];
            got_im[k] = res_data[15:0];
            if (k == stall_k) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk($sformatf("stall_valid_c%0d", c), res_valid, 1);
                    chk($sformatf("stall_data_c%0d", c), res_data, stall_exp);
                    chk($sformatf("stall_index_c%0d", c), res_index, k);
                    chk($sformatf("stall_smp_addr_c%0d", c), smp_addr, npts - 1);
                end
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("done_pulse_n%0d", npts), done, 1);
        @(negedge clk);
        chk($sformatf("done_drop_n%0d", npts), done, 0);
        chk($sformatf("busy_drop_n%0d", npts), busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b1;
        start       = 1'b0;
        res_ready   = 1'b0;
        points_m1   = '0;
        scale_shift = '0;
`ifdef INVERSE_DFT_EN
        inverse     = 1'b0;
`endif
        rom_n       = 4;
        mon_en      = 1'b0;
        seen_valid  = 1'b0;
        set_samples(0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        chk("rst_smp_addr", smp_addr, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        // Impulse, with backpressure on bin 2
        set_samples(1000, 0, 0, 0, 0);
        run(4, 0, 1'b0, 2, {16'd1000, 16'd0}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("imp_re_k%0d", k), got_re[k], 1000);
            chk($sformatf("imp_im_k%0d", k), got_im[k], 0);
        end

        // DC, with twiddle address trace
        set_samples(1000, 1000, 1000, 1000, 1000);
        tw_log.delete();
        mon_en = 1'b1;
        run(4, 0, 1'b0, -1, 32'd0, 1'b0);
        mon_en = 1'b0;
        chk("dc_re_k0", got_re[0], 4000);
        chk("dc_im_k0", got_im[0], 0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("dc_re_k%0d", k), got_re[k], 0);
            chk($sformatf("dc_im_k%0d", k), got_im[k], 0);
        end
        chk("dc_twlog_len", tw_log.size(), 16);
        chk("tw_k1_n0", tw_log[4], 0);
        chk("tw_k1_n1", tw_log[5], 1);
        chk("tw_k1_n2", tw_log[6], 2);
        chk("tw_k1_n3", tw_log[7], 3);
        chk("tw_k2_n0", tw_log[8], 0);
        chk("tw_k2_n1", tw_log[9], 2);
        chk("tw_k2_n2", tw_log[10], 0);
        chk("tw_k2_n3", tw_log[11], 2);

        // Saturation; start and config changes while busy must be ignored
        set_samples(30000, 30000, 30000, 30000, 30000);
        run(8, 0, 1'b0, -1, 32'd0, 1'b1);
        chk("sat0_re_k0", got_re[0], 32767);
        chk("sat0_im_k0", got_im[0], 0);
        chk("sat0_re_k4", got_re[4], 0);
        chk("sat0_flag", sat_flag, 1);
        run(8, 3, 1'b0, -1, 32'd0, 1'b0);
        chk("sat3_re_k0", got_re[0], 29999);
        chk("sat3_im_k0", got_im[0], 0);
        chk("sat3_flag", sat_flag, 0);

        // Shifted impulse, forward transform
        set_samples(0, 1000, 0, 0, 0);
        run(4, 0, 1'b0, -1, 32'd0, 1'b0);
        chk("fwd_re_k0", got_re[0], 1000);
        chk("fwd_im_k0", got_im[0], 0);
        chk("fwd_re_k1", got_re[1], 0);
        chk("fwd_im_k1", got_im[1], -1000);
        chk("fwd_re_k2", got_re[2], -1000);
        chk("fwd_im_k3", got_im[3], 1000);
`ifdef INVERSE_DFT_EN
        run(4, 0, 1'b1, -1, 32'd0, 1'b0);
        chk("inv_re_k1", got_re[1], 0);
        chk("inv_im_k1", got_im[1], 1000);
        chk("inv_im_k3", got_im[3], -1000);
`endif

        // Reset in the middle of ISSUE
        points_m1   = 12'd7;
        scale_shift = 4'd0;
        rom_n       = 8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_smp_addr", smp_addr, 0);
        chk("mid_rst_tw_addr", tw_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_index", res_index, 0);
        Reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            seen_valid = seen_valid | res_valid;
        end
        chk("no_valid_after_rst", seen_valid, 0);

        // N = 1 after the aborted transform
        smp_mem[0].re = 16'(1234);
        smp_mem[0].im = 16'(-567);
        run(1, 0, 1'b0, -1, 32'd0, 1'b0);
        chk("n1_re", got_re[0], 1234);
        chk("n1_im", got_im[0], -567);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dft_mac_engine.md
Name: dft_mac_engine

Overview:
Parametrised successor of the direct-DFT compute path (n/k counters, twiddle lookup, multiply, round, accumulate). It computes X[k] = sum over n of x[n]·W^(kn) for complex samples and runtime N.
- Reads samples from an external RAM and twiddles from an external ROM.
- Twiddle index comes from an incremental phase accumulator, so no k·n multiplier.
- Emits each bin over a valid/ready stream.
- Sits between the sample RAM/cache and the AXI bridge write-back.

Parameters:
DATA_W, 16, sample/result component width, signed
TW_W, 16, twiddle component width, signed Q1.(TW_W-1)
ADDR_W, 12, index width; max N = 2^ADDR_W

Ports:
clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begin transform when idle
points_m1  in  ADDR_W  N-1, latched at start
scale_shift  in  $clog2(ADDR_W+1)  extra right shift on results, latched at start
smp_addr  out  ADDR_W  sample RAM read address (n)
smp_rdata  in  2*DATA_W  {re,im}, valid 1 cycle after smp_addr
tw_addr  out  ADDR_W  twiddle ROM address, (k·n) mod N
tw_rdata  in  2*TW_W  {re,im} of exp(-j2π·tw_addr/N), valid 1 cycle after tw_addr
res_valid  out  1  result available
res_ready  in  1  consumer accepts
res_data  out  2*DATA_W  {re,im} rounded, saturated X[k]
res_index  out  ADDR_W  k of res_data
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last bin handshake
sat_flag  out  1  sticky; any component saturated this transform

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulators/counters/phase 0. Reset mid-transform aborts with no further res_valid.
- FSM states and transitions:
  - IDLE: start → latch points_m1 and scale_shift, k=0, clear sat_flag → ISSUE.
  - ISSUE: one address pair per cycle for n=0..N-1. smp_addr=n, tw_addr=p. Next p = p+k, minus N if ≥N (sum width ADDR_W+1). At n=N-1 → DRAIN.
  - DRAIN: 2 cycles, flushing the read-latency and product-register stages → OUT.
  - OUT: res_valid=1 and res_data/res_index held stable until res_ready.
    - On handshake, if k==N-1 → DONE.
    - Otherwise k++, n=0, p=0, accumulator cleared → ISSUE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- start is ignored while busy.
- Pipeline:
  - Stage 1: address issue.
  - Stage 2: register complex products pr = xr·wr − xi·wi and pi = xr·wi + xi·wr. Width DATA_W+TW_W+1.
  - Stage 3: accumulate into ACC_W = DATA_W+TW_W+ADDR_W+1 bits. No wrap is possible.
- Per-bin cycles: N + 2 + 1 minimum, plus the stall time while res_ready is low.
- Output conversion per component:
  - Arithmetic shift right by (TW_W-1)+scale_shift, round half-up by adding 1 at bit (shift-1).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any saturation sets sat_flag.
  - Conversion is registered on entry to OUT.
- N=1 (points_m1=0) is legal: one bin, X[0]=x[0]·W^0.
- points_m1 and scale_shift may change while busy with no effect.

Optional Feature:
INVERSE_DFT_EN:
- Defined: adds port inverse (in, 1, latched at start). When 1, tw_rdata imag is negated before multiply (conjugate twiddle, IDFT without 1/N; normalise via scale_shift).
- Undefined: port absent, forward DFT only. Logic is identical otherwise.

Decomposition:
- Package dft_pkg:
  - state enum (IDLE, ISSUE, DRAIN, OUT, DONE)
  - complex_t struct typedef parameterised via localparams
  - default width constants
  - the saturate/round function
- Sub-module dft_cmac: registered complex multiply plus accumulator with clear/enable, and the round/saturate output.
- FSM, counters and phase accumulator stay in the top.

Test Plan:
- Impulse: N=4, x=[1000,0,0,0] (imag 0), Q15 ROM with 32767 for 1 → X[0..3] all re=1000, im=0, res_index 0..3, done once.
- DC: N=4, x=1000 every n → X[0].re=4000, X[1..3]=0 (±0); check tw_addr sequence for k=1 is 0,1,2,3 and for k=2 is 0,2,0,2.
- Saturation/scale: N=8, x=30000 → with scale_shift=0, X[0].re=32767 and sat_flag=1; rerun with scale_shift=3 → X[0].re=29999, sat_flag=0.
- Backpressure: hold res_ready low 5 cycles in OUT → res_valid stays 1, res_data/res_index unchanged, no new smp_addr activity; the bin completes after release.
- Control edges:
  - start pulsed while busy → ignored.
  - Reset asserted mid-ISSUE → all outputs 0 next edge.
  - New start → correct results.
  - N=1 → single bin equal to x[0].
- INVERSE_DFT_EN: N=4, x=[0,1000,0,0] → forward X[1]=(0,−1000), inverse X[1]=(0,+1000).
